// File: rtl/alu_exec_unit_if.sv
// Handshake/operand bundle between the ALU decoder/control FSM (master) and alu_exec_unit (slave).
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [2:0]       ALUControl;
  logic [1:0]       FlagW;
  logic             NoWrite;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;
  logic             WriteEn;

  modport master (
    output Start, ALUControl, FlagW, NoWrite, SrcA, SrcB,
    input  Busy, Done, Result, ALUFlags, WriteEn
  );

  modport slave (
    input  Start, ALUControl, FlagW, NoWrite, SrcA, SrcB,
    output Busy, Done, Result, ALUFlags, WriteEn
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle ADD/SUB/AND/OR/SLR, iterative shift-add MUL, NZCV flag register.
// Define ALU_FAST_MUL_EN to compute MUL combinationally in one cycle (Busy tied low).
module alu_exec_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned ShW   = $clog2(WIDTH);
  localparam logic [2:0]  OpSub = 3'b001;
  localparam logic [2:0]  OpAnd = 3'b010;
  localparam logic [2:0]  OpOr  = 3'b011;
  localparam logic [2:0]  OpMul = 3'b100;
  localparam logic [2:0]  OpSlr = 3'b101;

  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic             we_q, we_d;

  logic [WIDTH-1:0] alu_res, b_eff;
  logic [WIDTH:0]   sum;
  logic [ShW-1:0]   shamt, shamt_m1;
  logic             alu_c, alu_v;

`ifndef ALU_FAST_MUL_EN
  typedef enum logic [0:0] {StIdle, StMult} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, mul_step;
  logic [ShW-1:0]   cnt_q, cnt_d;
  logic [1:0]       flagw_q, flagw_d;
  logic             nowrite_q, nowrite_d;
`endif

  function automatic logic [3:0] upd_flags(input logic [3:0] old, input logic [1:0] fw,
                                           input logic [WIDTH-1:0] res, input logic c,
                                           input logic v);
    logic [3:0] f;
    f = old;
    if (fw[1]) f[3:2] = {res[WIDTH-1], res == '0};
    if (fw[0]) f[1:0] = {c, v};
    return f;
  endfunction

  // SUB is A + ~B + 1 so carry-out means "no borrow"; 11x falls through as ADD.
  always_comb begin
    b_eff    = (bus.ALUControl == OpSub) ? ~bus.SrcB : bus.SrcB;
    sum      = {1'b0, bus.SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.ALUControl == OpSub};
    shamt    = bus.SrcB[ShW-1:0];
    shamt_m1 = shamt - ShW'(1);
    alu_res  = sum[WIDTH-1:0];
    alu_c    = sum[WIDTH];
    alu_v    = (bus.SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.SrcA[WIDTH-1]);
    case (bus.ALUControl)
      OpAnd: begin
        alu_res = bus.SrcA & bus.SrcB;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      OpOr: begin
        alu_res = bus.SrcA | bus.SrcB;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      OpSlr: begin
        alu_res = bus.SrcA >> shamt;
        alu_c   = (shamt != '0) && bus.SrcA[shamt_m1];
        alu_v   = 1'b0;
      end
`ifdef ALU_FAST_MUL_EN
      OpMul: begin
        alu_res = bus.SrcA * bus.SrcB;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
`ifdef ALU_FAST_MUL_EN
    if (bus.Start) begin
      result_d = alu_res;
      flags_d  = upd_flags(flags_q, bus.FlagW, alu_res, alu_c, alu_v);
      done_d   = 1'b1;
      we_d     = ~bus.NoWrite;
    end
`else
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    flagw_d   = flagw_q;
    nowrite_d = nowrite_q;
    mul_step  = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);
    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          flagw_d   = bus.FlagW;
          nowrite_d = bus.NoWrite;
          if (bus.ALUControl == OpMul) begin
            state_d = StMult;
            a_d     = bus.SrcA;
            b_d     = bus.SrcB;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            result_d = alu_res;
            flags_d  = upd_flags(flags_q, bus.FlagW, alu_res, alu_c, alu_v);
            done_d   = 1'b1;
            we_d     = ~bus.NoWrite;
          end
        end
      end
      StMult: begin
        acc_d = mul_step;
        cnt_d = cnt_q + ShW'(1);
        if (cnt_q == ShW'(WIDTH - 1)) begin
          state_d  = StIdle;
          result_d = mul_step;
          flags_d  = upd_flags(flags_q, flagw_q, mul_step, 1'b0, 1'b0);
          done_d   = 1'b1;
          we_d     = ~nowrite_q;
        end
      end
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      flags_q   <= '0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
`ifndef ALU_FAST_MUL_EN
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      flagw_q   <= '0;
      nowrite_q <= 1'b0;
`endif
    end else begin
      result_q  <= result_d;
      flags_q   <= flags_d;
      done_q    <= done_d;
      we_q      <= we_d;
`ifndef ALU_FAST_MUL_EN
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      flagw_q   <= flagw_d;
      nowrite_q <= nowrite_d;
`endif
    end
  end

`ifdef ALU_FAST_MUL_EN
  assign bus.Busy = 1'b0;
`else
  assign bus.Busy = (state_q == StMult);
`endif
  assign bus.Done     = done_q;
  assign bus.Result   = result_q;
  assign bus.ALUFlags = flags_q;
  assign bus.WriteEn  = we_q;
endmodule
